cache_access_ctrl: RTL and testbench
====================================

Name: cache_access_ctrl

Overview:
- Sequences every CPU access to the 8-way set-associative data cache: lookup, hit response, miss handling (victim selection, dirty writeback, line fill) and tag-store update.
- Drives index/tag into the existing combinational hit-compare block and consumes its hit/way result.
- Keeps per-set tree pseudo-LRU state and picks the victim on misses.
- Sits between the CPU request port and the next-level memory interface.

Parameters:
- WAYS, 8, associativity (fixed tree depth of 3 levels)
- WAYS_REP, 3, way-index width, log2(WAYS)
- INDEX, 14, set-index width; PLRU array has 2^INDEX entries
- TAG, 12, tag width
- OFFSET, 6, byte-offset width; ADDR = TAG+INDEX+OFFSET = 32

Ports:
- clk  in  1  clock, all state on rising edge
- rstb  in  1  synchronous, active-high reset (rstb==1 at a rising edge resets)
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  32  {tag, index, offset}
- lkp_index  out  INDEX  set index to tag store / hit block
- lkp_tag  out  TAG  tag to hit block
- lkp_hit  in  1  hit-compare result (combinational from lkp_*)
- lkp_way  in  WAYS_REP  hitting way
- lkp_inv_vec  in  WAYS  per-way invalid flags of the indexed set
- vic_way  out  WAYS_REP  chosen victim way
- vic_dirty  in  1  dirty flag of vic_way in the indexed set (combinational)
- mem_req  out  1  memory transaction request, held until mem_ack
- mem_wb  out  1  1=writeback of victim, 0=line fill
- mem_ack  in  1  one-cycle completion pulse
- upd_en  out  1  one-cycle tag-store write strobe
- upd_way  out  WAYS_REP  way written
- upd_dirty  out  1  dirty value written (= req_we)
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  1 = access hit
- resp_way  out  WAYS_REP  way serviced

Behaviour:
- States: IDLE, LOOKUP, EVICT, FILL, RESP. All transitions below occur on the rising edge.
- Reset: state=IDLE, all PLRU bits 0, req_ready=1. mem_req, mem_wb, upd_en, resp_valid, resp_hit, resp_way, vic_way, upd_way and upd_dirty are all 0. Reset mid-transaction abandons it and leaves no pending mem_req.
- IDLE: req_ready=1. On req_valid, register addr and we, then go to LOOKUP.
- LOOKUP: lkp_index and lkp_tag come from the registered address. Outputs are valid from LOOKUP until return to IDLE.
- LOOKUP, lkp_hit=1:
  - go to RESP with resp_hit=1 and resp_way=lkp_way.
  - update PLRU with lkp_way.
  - if req_we, pulse upd_en with upd_way=lkp_way and upd_dirty=1.
- LOOKUP, miss: latch vic_way. If vic_dirty=1 go to EVICT, else go to FILL.
- Victim choice:
  - if any lkp_inv_vec bit is set, take the lowest-numbered invalid way; vic_dirty is ignored (treated 0).
  - otherwise take the PLRU victim.
- EVICT: mem_req=1, mem_wb=1. On mem_ack go to FILL.
- FILL: mem_req=1, mem_wb=0. On mem_ack:
  - pulse upd_en with upd_way=vic_way and upd_dirty=req_we.
  - update PLRU with vic_way.
  - go to RESP with resp_hit=0 and resp_way=vic_way.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency, req_valid sampled at edge 0:
  - hit: resp_valid is high in cycle 2.
  - miss: resp_valid is one cycle after the final mem_ack.
- mem_ack outside EVICT/FILL is ignored. req_valid is ignored while req_ready=0.
- PLRU layout, 7 bits per set:
  - b0 is the root.
  - b1 covers ways 0-3; b2 covers ways 4-7.
  - b3..b6 cover way pairs (0,1), (2,3), (4,5), (6,7).
- PLRU victim v: v[2]=b0, v[1]=b[1+v[2]], v[0]=b[3+v[2:1]].
- PLRU access to way w sets b0=~w[2], b[1+w[2]]=~w[1], b[3+w[2:1]]=~w[0]; all other bits are unchanged.
- The PLRU write occurs at the same edge as the state change out of LOOKUP (hit) or FILL. A subsequent request to the same set sees the updated bits.

Decomposition:
- Shared package (cache struct package):
  - WAYS, WAYS_REP, TAG, INDEX, OFFSET.
  - state enum ctrl_state_t.
  - plru_t (7-bit packed).
  - address field slicing helpers.
- Sub-module cache_plru, with a state array of 2^INDEX x 7 bits:
  - combinational victim output for a read index.
  - synchronous update port (en, index, way).
  - synchronous active-high reset that clears the array.

Test Plan:
- Reset, then read addr 0x0000_0040 with all ways invalid -> miss, vic_way=0, mem_req with mem_wb=0; mem_ack -> upd_en with way 0 and upd_dirty 0, resp_valid with resp_hit=0.
- Same set, lkp_hit=1, lkp_way=5 -> resp_valid at cycle 2, resp_hit=1, resp_way=5, no mem_req. PLRU bits become b0=0, b2=1, b5=0 -> next victim way 0.
- Full set, all valid, PLRU=0, vic_dirty=1, write miss -> EVICT (mem_wb=1), then FILL, then upd_dirty=1, resp_way=0.
- Write hit on way 3 -> single upd_en with upd_way=3 and upd_dirty=1; no memory traffic.
- Eight consecutive fills of one set, all valid, no hits -> victims in order 0,4,2,6,1,5,3,7.
- rstb asserted during FILL with mem_req high -> mem_req=0 next cycle, state IDLE, PLRU cleared, and a following mem_ack is ignored.

Source files
------------

// File: rtl/cache_access_ctrl_pkg.sv
// cache_access_ctrl_pkg
//   Shared types and helpers for the data-cache access controller.
//   - Geometry: WAYS, WAYS_REP, INDEX, TAG, OFFSET, ADDR.
//   - ctrl_state_t: controller FSM state encoding.
//   - plru_t: 7-bit tree pseudo-LRU state of one set.
//       b0 is the root, b1/b2 choose within ways 0-3 / 4-7,
//       b3..b6 choose within the pairs (0,1), (2,3), (4,5), (6,7).
//   - Helpers: address field extraction, PLRU victim and PLRU touch.
package cache_access_ctrl_pkg;

  localparam int WAYS     = 8;
  localparam int WAYS_REP = 3;
  localparam int INDEX    = 14;
  localparam int TAG      = 12;
  localparam int OFFSET   = 6;
  localparam int ADDR     = TAG + INDEX + OFFSET;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    EVICT  = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } ctrl_state_t;

  typedef logic [6:0] plru_t;

  function automatic logic [INDEX-1:0] addr_index(input logic [ADDR-1:0] addr);
    return addr[OFFSET +: INDEX];
  endfunction

  function automatic logic [TAG-1:0] addr_tag(input logic [ADDR-1:0] addr);
    return addr[OFFSET+INDEX +: TAG];
  endfunction

  // Follow the tree bits from the root down to a leaf.
  function automatic logic [WAYS_REP-1:0] plru_victim(input plru_t b);
    logic [WAYS_REP-1:0] v;
    logic [2:0]          leaf;
    v[2] = b[0];
    v[1] = v[2] ? b[2] : b[1];
    leaf = 3'd3 + {1'b0, v[2:1]};
    v[0] = b[leaf];
    return v;
  endfunction

  // Point every node on the path to way w away from w.
  function automatic plru_t plru_touch(input plru_t b, input logic [WAYS_REP-1:0] w);
    plru_t      r;
    logic [2:0] mid;
    logic [2:0] leaf;
    r       = b;
    mid     = 3'd1 + {2'b00, w[2]};
    leaf    = 3'd3 + {1'b0, w[2:1]};
    r[0]    = ~w[2];
    r[mid]  = ~w[1];
    r[leaf] = ~w[0];
    return r;
  endfunction

endpackage

// File: rtl/cache_access_ctrl_plru.sv
// cache_plru
//   Per-set tree pseudo-LRU state store (2^INDEX entries of plru_t).
//   Ports:
//     clk, rst      - clock, synchronous active-high reset clearing every set
//     rd_index      - set whose victim is reported
//     victim        - combinational PLRU victim way of rd_index
//     upd_en        - record an access this cycle
//     upd_index     - set being accessed
//     upd_way       - way being accessed
module cache_plru
  import cache_access_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX-1:0]    rd_index,
  output logic [WAYS_REP-1:0] victim,
  input  logic                upd_en,
  input  logic [INDEX-1:0]    upd_index,
  input  logic [WAYS_REP-1:0] upd_way
);

  localparam int SETS = 1 << INDEX;

  plru_t bits_q [SETS];

  assign victim = plru_victim(bits_q[rd_index]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        bits_q[i] <= '0;
      end
    end else if (upd_en) begin
      bits_q[upd_index] <= plru_touch(bits_q[upd_index], upd_way);
    end
  end

endmodule

// File: rtl/cache_access_ctrl.sv
// cache_access_ctrl
//   Sequences CPU accesses to an 8-way set-associative data cache:
//   lookup, hit response, victim selection, dirty writeback, line fill
//   and tag-store update.
//   Ports:
//     clk, rstb                 - clock, synchronous active-high reset
//     req_valid/req_ready       - CPU request handshake; req_we, req_addr
//     lkp_index, lkp_tag        - to the combinational hit-compare block
//     lkp_hit, lkp_way          - hit result and hitting way
//     lkp_inv_vec               - per-way invalid flags of the indexed set
//     vic_way, vic_dirty        - chosen victim and its dirty flag
//     mem_req, mem_wb, mem_ack  - next-level memory transaction
//     upd_en, upd_way, upd_dirty- tag-store write strobe
//     resp_valid, resp_hit, resp_way - one-cycle CPU response
//     dbg_state                 - current FSM state
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1; req_ready stays 0 until the response has been
//   given. mem_req is held high until a one-cycle mem_ack pulse; mem_ack
//   at any other time is ignored.
module cache_access_ctrl
  import cache_access_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rstb,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR-1:0]     req_addr,
  output logic [INDEX-1:0]    lkp_index,
  output logic [TAG-1:0]      lkp_tag,
  input  logic                lkp_hit,
  input  logic [WAYS_REP-1:0] lkp_way,
  input  logic [WAYS-1:0]     lkp_inv_vec,
  output logic [WAYS_REP-1:0] vic_way,
  input  logic                vic_dirty,
  output logic                mem_req,
  output logic                mem_wb,
  input  logic                mem_ack,
  output logic                upd_en,
  output logic [WAYS_REP-1:0] upd_way,
  output logic                upd_dirty,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAYS_REP-1:0] resp_way,
  output ctrl_state_t         dbg_state
);

  ctrl_state_t         state;
  logic [ADDR-1:0]     addr_q;
  logic                we_q;
  logic [WAYS_REP-1:0] vic_q;

  logic [WAYS_REP-1:0] plru_vic;
  logic [WAYS_REP-1:0] inv_way;
  logic                inv_any;
  logic [WAYS_REP-1:0] vic_sel;
  logic                vic_needs_wb;
  logic                plru_upd_en;
  logic [WAYS_REP-1:0] plru_upd_way;

  assign lkp_index = addr_index(addr_q);
  assign lkp_tag   = addr_tag(addr_q);
  assign dbg_state = state;

  // Lowest-numbered invalid way wins over the PLRU choice; an invalid
  // line never needs a writeback whatever vic_dirty says.
  always_comb begin
    inv_way = '0;
    inv_any = |lkp_inv_vec;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (lkp_inv_vec[i]) inv_way = i[WAYS_REP-1:0];
    end
    vic_sel      = inv_any ? inv_way : plru_vic;
    vic_needs_wb = !inv_any && vic_dirty;
  end

  // During LOOKUP the victim is still being chosen, so the dirty lookup
  // outside needs the live selection; afterwards the latched way is shown.
  assign vic_way = (state == LOOKUP) ? vic_sel : vic_q;

  always_comb begin
    plru_upd_en  = 1'b0;
    plru_upd_way = vic_q;
    if (state == LOOKUP && lkp_hit) begin
      plru_upd_en  = 1'b1;
      plru_upd_way = lkp_way;
    end else if (state == FILL && mem_ack) begin
      plru_upd_en  = 1'b1;
      plru_upd_way = vic_q;
    end
  end

  cache_plru u_plru (
    .clk       (clk),
    .rst       (rstb),
    .rd_index  (lkp_index),
    .victim    (plru_vic),
    .upd_en    (plru_upd_en),
    .upd_index (lkp_index),
    .upd_way   (plru_upd_way)
  );

  always_ff @(posedge clk) begin
    if (rstb) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      vic_q      <= '0;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_wb     <= 1'b0;
      upd_en     <= 1'b0;
      upd_way    <= '0;
      upd_dirty  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      upd_en     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lkp_hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_way   <= lkp_way;
            if (we_q) begin
              upd_en    <= 1'b1;
              upd_way   <= lkp_way;
              upd_dirty <= 1'b1;
            end
            state <= RESP;
          end else begin
            vic_q   <= vic_sel;
            mem_req <= 1'b1;
            mem_wb  <= vic_needs_wb;
            state   <= vic_needs_wb ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (mem_ack) begin
            mem_wb <= 1'b0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            upd_en     <= 1'b1;
            upd_way    <= vic_q;
            upd_dirty  <= we_q;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_way   <= vic_q;
            state      <= RESP;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          mem_wb    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_access_ctrl.sv
module tb_cache_access_ctrl;
  import cache_access_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rstb = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_we = 1'b0;
  logic [ADDR-1:0]     req_addr = '0;
  logic [INDEX-1:0]    lkp_index;
  logic [TAG-1:0]      lkp_tag;
  logic                lkp_hit = 1'b0;
  logic [WAYS_REP-1:0] lkp_way = '0;
  logic [WAYS-1:0]     lkp_inv_vec = '0;
  logic [WAYS_REP-1:0] vic_way;
  logic                vic_dirty = 1'b0;
  logic                mem_req;
  logic                mem_wb;
  logic                mem_ack = 1'b0;
  logic                upd_en;
  logic [WAYS_REP-1:0] upd_way;
  logic                upd_dirty;
  logic                resp_valid;
  logic                resp_hit;
  logic [WAYS_REP-1:0] resp_way;
  ctrl_state_t         dbg_state;

  always #5 clk = ~clk;

  cache_access_ctrl dut (
    .clk         (clk),
    .rstb        (rstb),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .lkp_index   (lkp_index),
    .lkp_tag     (lkp_tag),
    .lkp_hit     (lkp_hit),
    .lkp_way     (lkp_way),
    .lkp_inv_vec (lkp_inv_vec),
    .vic_way     (vic_way),
    .vic_dirty   (vic_dirty),
    .mem_req     (mem_req),
    .mem_wb      (mem_wb),
    .mem_ack     (mem_ack),
    .upd_en      (upd_en),
    .upd_way     (upd_way),
    .upd_dirty   (upd_dirty),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_way    (resp_way),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int ack_cyc = 0;
  int resp_seen = 0;
  bit mem_en = 1'b1;
  logic [3:0] resp_q[$];  // {hit, way}
  logic [3:0] upd_q[$];   // {dirty, way}
  logic [3:0] mem_q[$];   // {wb, way}

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDR-1:0] mk_addr(input logic [TAG-1:0] t, input logic [INDEX-1:0] ix);
    return {t, ix, 6'b000000};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    rstb = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  // One CPU access with the hit-block answer supplied for its lookup.
  // Expected responses are pushed before the request is issued.
  task automatic access(input logic we, input logic [TAG-1:0] t, input logic [INDEX-1:0] ix,
                        input logic hit, input logic [2:0] hway, input logic [7:0] inv,
                        input logic vd, input logic [2:0] exp_way);
    int start;
    int n;
    if (hit) begin
      resp_q.push_back({1'b1, hway});
      if (we) upd_q.push_back({1'b1, hway});
    end else begin
      if (inv == 8'h00 && vd) mem_q.push_back({1'b1, exp_way});
      mem_q.push_back({1'b0, exp_way});
      upd_q.push_back({we, exp_way});
      resp_q.push_back({1'b0, exp_way});
    end
    wait_ready();
    lkp_hit     = hit;
    lkp_way     = hway;
    lkp_inv_vec = inv;
    vic_dirty   = vd;
    req_we      = we;
    req_addr    = mk_addr(t, ix);
    req_valid   = 1'b1;
    accept_cyc  = cyc + 1;
    start       = resp_seen;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_seen == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_timeout", {31'b0, (resp_seen == start)}, 32'd0);
  endtask

  // ---------------- memory responder ----------------
  initial forever begin
    @(negedge clk);
    while (mem_en && mem_req) begin
      logic [3:0] e;
      if (mem_q.size() == 0) begin
        check("mem_unexpected", 32'd1, 32'd0);
      end else begin
        e = mem_q.pop_front();
        check("mem_wb", {31'b0, mem_wb}, {31'b0, e[3]});
        check("mem_vic_way", {29'b0, vic_way}, {29'b0, e[2:0]});
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mem_ack = 1'b1;
      ack_cyc = cyc + 1;
      @(negedge clk);
      mem_ack = 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    if (resp_valid) begin
      resp_seen++;
      if (resp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = resp_q.pop_front();
        check("resp_hit", {31'b0, resp_hit}, {31'b0, e[3]});
        check("resp_way", {29'b0, resp_way}, {29'b0, e[2:0]});
        if (e[3]) check("hit_latency", cyc - accept_cyc, 32'd1);
        else      check("miss_latency", cyc, ack_cyc);
      end
    end
    if (upd_en) begin
      if (upd_q.size() == 0) begin
        check("upd_unexpected", 32'd1, 32'd0);
      end else begin
        e = upd_q.pop_front();
        check("upd_dirty", {31'b0, upd_dirty}, {31'b0, e[3]});
        check("upd_way", {29'b0, upd_way}, {29'b0, e[2:0]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [2:0] seq8 [8];

  initial begin
    int n;
    seq8 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    do_reset();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_state", {29'b0, dbg_state}, {29'b0, IDLE});
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_wb", {31'b0, mem_wb}, 32'd0);
    check("rst_upd_en", {31'b0, upd_en}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_hit", {31'b0, resp_hit}, 32'd0);
    check("rst_resp_way", {29'b0, resp_way}, 32'd0);
    check("rst_vic_way", {29'b0, vic_way}, 32'd0);
    check("rst_upd_way", {29'b0, upd_way}, 32'd0);
    check("rst_upd_dirty", {31'b0, upd_dirty}, 32'd0);

    // Read 0x0000_0040, all ways invalid: clean fill into way 0.
    access(1'b0, 12'h000, 14'd1, 1'b0, 3'd0, 8'hFF, 1'b0, 3'd0);
    check("lkp_index", {18'b0, lkp_index}, 32'd1);
    check("lkp_tag", {20'b0, lkp_tag}, 32'd0);

    // Fresh PLRU, read hit on way 5, then a full clean miss picks way 0.
    do_reset();
    access(1'b0, 12'hABC, 14'd5, 1'b1, 3'd5, 8'h00, 1'b0, 3'd5);
    check("lkp_tag_abc", {20'b0, lkp_tag}, 32'h0ABC);
    access(1'b0, 12'h123, 14'd5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

    // Write miss, full set, victim dirty: writeback then fill of way 0.
    access(1'b1, 12'h055, 14'd7, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    // Write hit way 3, then a read hit way 2 with no tag update.
    access(1'b1, 12'h055, 14'd7, 1'b1, 3'd3, 8'h00, 1'b0, 3'd3);
    access(1'b0, 12'h055, 14'd7, 1'b1, 3'd2, 8'h00, 1'b1, 3'd2);

    // Eight fills of one fresh set walk the whole PLRU tree.
    for (int i = 0; i < 8; i++) begin
      access(i[0], 12'h200 + 12'(i), 14'h100, 1'b0, 3'd0, 8'h00, 1'b0, seq8[i]);
    end

    // Invalid ways take priority and suppress the writeback.
    access(1'b0, 12'h300, 14'h200, 1'b0, 3'd0, 8'b0010_1000, 1'b1, 3'd3);
    access(1'b1, 12'h301, 14'h201, 1'b0, 3'd0, 8'b1000_0000, 1'b1, 3'd7);

    // Reset in the middle of a fill of set 5 (PLRU victim there is 6).
    mem_en = 1'b0;
    wait_ready();
    lkp_hit = 1'b0; lkp_inv_vec = 8'h00; vic_dirty = 1'b0;
    req_we = 1'b0; req_addr = mk_addr(12'h777, 14'd5);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (dbg_state != FILL && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fill_state", {29'b0, dbg_state}, {29'b0, FILL});
    check("fill_mem_req", {31'b0, mem_req}, 32'd1);
    check("fill_vic_way", {29'b0, vic_way}, 32'd6);
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check("midrst_state", {29'b0, dbg_state}, {29'b0, IDLE});
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_state", {29'b0, dbg_state}, {29'b0, IDLE});
    check("stray_ack_mem_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    mem_en = 1'b1;
    // PLRU of set 5 was cleared by the reset.
    access(1'b0, 12'h778, 14'd5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);

    repeat (4) @(negedge clk);
    check("resp_q_empty", resp_q.size(), 32'd0);
    check("upd_q_empty", upd_q.size(), 32'd0);
    check("mem_q_empty", mem_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
